// File: rtl/ddr2_idelay_rst_seq.sv
`default_nettype none
// ============================================================================
// Module   : ddr2_idelay_rst_seq
// Brief    : IDELAYCTRL reset sequencer. Pulses RST after PLL lock, qualifies
//            RDY, retries on timeout or RDY loss, and releases PHY init.
// Revision : 1.0 - initial release
// ============================================================================
module ddr2_idelay_rst_seq #(
  parameter int RST_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int STABLE_CYCLES  = 8,
  parameter int MAX_RETRY      = 3
) (
  input  logic       clk200,
  input  logic       rst200,
  input  logic       pll_locked,
  input  logic       idelay_ctrl_rdy,
  output logic       idelayctrl_rst,
  output logic       phy_init_en,
  output logic [2:0] retry_cnt,
  output logic       fail
);

  localparam int c_tmo_w = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [7:0]         c_hold_last  = 8'(RST_CYCLES - 1);
  localparam logic [7:0]         c_stab_done  = 8'(STABLE_CYCLES);
  localparam logic [c_tmo_w-1:0] c_tmo_last   = c_tmo_w'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]         c_retry_max  = 3'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_HOLD     = 3'd1,
    S_WAIT_RDY = 3'd2,
    S_DONE     = 3'd3,
    S_FAIL     = 3'd4
  } state_t;

  state_t               r_state;
  logic                 r_lock_meta;
  logic                 r_lock_s;
  logic                 r_rdy_meta;
  logic                 r_rdy_s;
  logic                 r_idelayctrl_rst;
  logic                 r_phy_init_en;
  logic [2:0]           r_retry_cnt;
  logic                 r_fail;
  logic [7:0]           r_hold_cnt;
  logic [7:0]           r_stab_cnt;
  logic [c_tmo_w-1:0]   r_tmo_cnt;
  logic                 w_can_retry;

  assign w_can_retry = (r_retry_cnt < c_retry_max);

  // Both inputs are asynchronous to clk200; only the second stages are used.
  always_ff @(posedge clk200 or posedge rst200) begin
    if (rst200) begin
      r_lock_meta <= 1'b0;
      r_lock_s    <= 1'b0;
      r_rdy_meta  <= 1'b0;
      r_rdy_s     <= 1'b0;
    end else begin
      r_lock_meta <= pll_locked;
      r_lock_s    <= r_lock_meta;
      r_rdy_meta  <= idelay_ctrl_rdy;
      r_rdy_s     <= r_rdy_meta;
    end
  end

  always_ff @(posedge clk200 or posedge rst200) begin
    if (rst200) begin
      r_state          <= S_IDLE;
      r_idelayctrl_rst <= 1'b1;
      r_phy_init_en    <= 1'b0;
      r_retry_cnt      <= 3'd0;
      r_fail           <= 1'b0;
      r_hold_cnt       <= 8'd0;
      r_stab_cnt       <= 8'd0;
      r_tmo_cnt        <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_idelayctrl_rst <= 1'b1;
          r_phy_init_en    <= 1'b0;
          if (r_lock_s) begin
            r_state    <= S_HOLD;
            r_hold_cnt <= 8'd0;
          end
        end

        S_HOLD: begin
          if (!r_lock_s) begin
            r_state          <= S_IDLE;
            r_idelayctrl_rst <= 1'b1;
            r_phy_init_en    <= 1'b0;
          end else if (r_hold_cnt == c_hold_last) begin
            r_state          <= S_WAIT_RDY;
            r_idelayctrl_rst <= 1'b0;
            r_tmo_cnt        <= '0;
            r_stab_cnt       <= 8'd0;
          end else begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
          end
        end

        // Qualification is checked before the timeout so a same-cycle tie
        // still releases the PHY.
        S_WAIT_RDY: begin
          if (!r_lock_s) begin
            r_state          <= S_IDLE;
            r_idelayctrl_rst <= 1'b1;
            r_phy_init_en    <= 1'b0;
          end else if (r_stab_cnt == c_stab_done) begin
            r_state       <= S_DONE;
            r_phy_init_en <= 1'b1;
          end else if (r_tmo_cnt == c_tmo_last) begin
            r_idelayctrl_rst <= 1'b1;
            r_phy_init_en    <= 1'b0;
            if (w_can_retry) begin
              r_state     <= S_HOLD;
              r_hold_cnt  <= 8'd0;
              r_retry_cnt <= r_retry_cnt + 1'b1;
            end else begin
              r_state <= S_FAIL;
              r_fail  <= 1'b1;
            end
          end else begin
            r_tmo_cnt  <= r_tmo_cnt + 1'b1;
            r_stab_cnt <= r_rdy_s ? (r_stab_cnt + 1'b1) : 8'd0;
          end
        end

        S_DONE: begin
          if (!r_lock_s) begin
            r_state          <= S_IDLE;
            r_idelayctrl_rst <= 1'b1;
            r_phy_init_en    <= 1'b0;
          end else if (!r_rdy_s) begin
            r_idelayctrl_rst <= 1'b1;
            r_phy_init_en    <= 1'b0;
            if (w_can_retry) begin
              r_state     <= S_HOLD;
              r_hold_cnt  <= 8'd0;
              r_retry_cnt <= r_retry_cnt + 1'b1;
            end else begin
              r_state <= S_FAIL;
              r_fail  <= 1'b1;
            end
          end
        end

        // Terminal until rst200; lock changes are deliberately ignored.
        S_FAIL: begin
          r_idelayctrl_rst <= 1'b1;
          r_phy_init_en    <= 1'b0;
          r_fail           <= 1'b1;
        end

        default: begin
          r_state          <= S_IDLE;
          r_idelayctrl_rst <= 1'b1;
          r_phy_init_en    <= 1'b0;
        end
      endcase
    end
  end

  assign idelayctrl_rst = r_idelayctrl_rst;
  assign phy_init_en    = r_phy_init_en;
  assign retry_cnt      = r_retry_cnt;
  assign fail           = r_fail;

endmodule
`default_nettype wire

// File: tb/tb_ddr2_idelay_rst_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_ddr2_idelay_rst_seq
// Brief    : Directed self-checking bench for ddr2_idelay_rst_seq.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ddr2_idelay_rst_seq;

  logic       clk200;
  logic       rst200;
  logic       pll_locked;
  logic       idelay_ctrl_rdy;
  logic       idelayctrl_rst;
  logic       phy_init_en;
  logic [2:0] retry_cnt;
  logic       fail;

  int total;
  int bad;

  ddr2_idelay_rst_seq dut (
    .clk200          (clk200),
    .rst200          (rst200),
    .pll_locked      (pll_locked),
    .idelay_ctrl_rdy (idelay_ctrl_rdy),
    .idelayctrl_rst  (idelayctrl_rst),
    .phy_init_en     (phy_init_en),
    .retry_cnt       (retry_cnt),
    .fail            (fail)
  );

  initial clk200 = 1'b0;
  always #5 clk200 = ~clk200;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk200);
    #1;
  endtask

  task automatic wait_rst(input logic lvl, input int bound, output int k);
    k = 0;
    do begin tick(1); k++; end while (idelayctrl_rst !== lvl && k < bound);
  endtask

  task automatic wait_phy(input logic lvl, input int bound, output int k);
    k = 0;
    do begin tick(1); k++; end while (phy_init_en !== lvl && k < bound);
  endtask

  task automatic do_reset();
    rst200 = 1'b1; pll_locked = 1'b0; idelay_ctrl_rdy = 1'b0;
    tick(3);
    rst200 = 1'b0;
  endtask

  task automatic test_reset();
    rst200 = 1'b1; pll_locked = 1'b0; idelay_ctrl_rdy = 1'b0;
    #1;
    total++; if (idelayctrl_rst !== 1'b1) begin bad++; $display("FAIL reset_rst: got %b want 1", idelayctrl_rst); end
    total++; if (phy_init_en !== 1'b0) begin bad++; $display("FAIL reset_phy: got %b want 0", phy_init_en); end
    total++; if (retry_cnt !== 3'd0) begin bad++; $display("FAIL reset_retry: got %0d want 0", retry_cnt); end
    total++; if (fail !== 1'b0) begin bad++; $display("FAIL reset_fail: got %b want 0", fail); end
    tick(3);
    rst200 = 1'b0;
  endtask

  task automatic test_nominal();
    int k;
    tick(10);
    pll_locked = 1'b1;
    wait_rst(1'b0, 100, k);
    total++; if (k !== 19) begin bad++; $display("FAIL nom_rst_fall: got %0d want 19", k); end
    tick(20);
    idelay_ctrl_rdy = 1'b1;
    wait_phy(1'b1, 100, k);
    total++; if (k !== 11) begin bad++; $display("FAIL nom_phy_rise: got %0d want 11", k); end
    total++; if (retry_cnt !== 3'd0) begin bad++; $display("FAIL nom_retry: got %0d want 0", retry_cnt); end
    total++; if (fail !== 1'b0) begin bad++; $display("FAIL nom_fail: got %b want 0", fail); end
    total++; if (idelayctrl_rst !== 1'b0) begin bad++; $display("FAIL nom_rst_low: got %b want 0", idelayctrl_rst); end
  endtask

  task automatic test_rdy_loss();
    int k;
    idelay_ctrl_rdy = 1'b0;
    wait_phy(1'b0, 100, k);
    total++; if (k !== 3) begin bad++; $display("FAIL rdyloss_phy_fall: got %0d want 3", k); end
    total++; if (idelayctrl_rst !== 1'b1) begin bad++; $display("FAIL rdyloss_rst: got %b want 1", idelayctrl_rst); end
    total++; if (retry_cnt !== 3'd1) begin bad++; $display("FAIL rdyloss_retry: got %0d want 1", retry_cnt); end
    wait_rst(1'b0, 100, k);
    total++; if (k !== 16) begin bad++; $display("FAIL rdyloss_pulse: got %0d want 16", k); end
    idelay_ctrl_rdy = 1'b1;
    wait_phy(1'b1, 100, k);
    total++; if (k !== 11) begin bad++; $display("FAIL rdyloss_requal: got %0d want 11", k); end
  endtask

  task automatic test_lock_loss();
    int k;
    pll_locked = 1'b0;
    wait_phy(1'b0, 100, k);
    total++; if (k !== 3) begin bad++; $display("FAIL lockloss_phy_fall: got %0d want 3", k); end
    total++; if (idelayctrl_rst !== 1'b1) begin bad++; $display("FAIL lockloss_rst: got %b want 1", idelayctrl_rst); end
    total++; if (retry_cnt !== 3'd1) begin bad++; $display("FAIL lockloss_retry: got %0d want 1", retry_cnt); end
    pll_locked = 1'b1;
    wait_rst(1'b0, 100, k);
    total++; if (k !== 19) begin bad++; $display("FAIL lockloss_relock: got %0d want 19", k); end
    wait_phy(1'b1, 100, k);
    total++; if (k !== 9) begin bad++; $display("FAIL lockloss_requal: got %0d want 9", k); end
    total++; if (retry_cnt !== 3'd1) begin bad++; $display("FAIL lockloss_retry_end: got %0d want 1", retry_cnt); end
  endtask

  task automatic test_timeout_retry();
    int k;
    do_reset();
    pll_locked = 1'b1;
    wait_rst(1'b0, 100, k);
    total++; if (k !== 19) begin bad++; $display("FAIL tmo_rst_fall: got %0d want 19", k); end
    wait_rst(1'b1, 5000, k);
    total++; if (k !== 4096) begin bad++; $display("FAIL tmo_len: got %0d want 4096", k); end
    total++; if (retry_cnt !== 3'd1) begin bad++; $display("FAIL tmo_retry: got %0d want 1", retry_cnt); end
    wait_rst(1'b0, 100, k);
    total++; if (k !== 16) begin bad++; $display("FAIL tmo_second_pulse: got %0d want 16", k); end
    idelay_ctrl_rdy = 1'b1;
    wait_phy(1'b1, 100, k);
    total++; if (k !== 11) begin bad++; $display("FAIL tmo_phy: got %0d want 11", k); end
    total++; if (retry_cnt !== 3'd1) begin bad++; $display("FAIL tmo_retry_end: got %0d want 1", retry_cnt); end
  endtask

  task automatic test_exhaustion();
    int k;
    do_reset();
    pll_locked = 1'b1;
    wait_rst(1'b0, 100, k);
    total++; if (k !== 19) begin bad++; $display("FAIL exh_rst_fall: got %0d want 19", k); end
    for (int a = 1; a <= 3; a++) begin
      wait_rst(1'b1, 5000, k);
      total++; if (k !== 4096) begin bad++; $display("FAIL exh_tmo%0d: got %0d want 4096", a, k); end
      total++; if (retry_cnt !== 3'(a)) begin bad++; $display("FAIL exh_retry%0d: got %0d want %0d", a, retry_cnt, a); end
      wait_rst(1'b0, 100, k);
      total++; if (k !== 16) begin bad++; $display("FAIL exh_pulse%0d: got %0d want 16", a, k); end
    end
    k = 0;
    do begin tick(1); k++; end while (fail !== 1'b1 && k < 5000);
    total++; if (k !== 4096) begin bad++; $display("FAIL exh_fail_time: got %0d want 4096", k); end
    total++; if (retry_cnt !== 3'd3) begin bad++; $display("FAIL exh_retry_max: got %0d want 3", retry_cnt); end
    total++; if (idelayctrl_rst !== 1'b1) begin bad++; $display("FAIL exh_rst: got %b want 1", idelayctrl_rst); end
    pll_locked = 1'b0;
    tick(10);
    total++; if (fail !== 1'b1) begin bad++; $display("FAIL exh_sticky_unlock: got %b want 1", fail); end
    pll_locked = 1'b1;
    tick(30);
    total++; if (fail !== 1'b1) begin bad++; $display("FAIL exh_sticky_relock: got %b want 1", fail); end
    total++; if (idelayctrl_rst !== 1'b1) begin bad++; $display("FAIL exh_rst_relock: got %b want 1", idelayctrl_rst); end
    total++; if (phy_init_en !== 1'b0) begin bad++; $display("FAIL exh_phy: got %b want 0", phy_init_en); end
    #2 rst200 = 1'b1;
    #1;
    total++; if (fail !== 1'b0) begin bad++; $display("FAIL exh_async_fail: got %b want 0", fail); end
    total++; if (retry_cnt !== 3'd0) begin bad++; $display("FAIL exh_async_retry: got %0d want 0", retry_cnt); end
    tick(2);
    rst200 = 1'b0;
  endtask

  task automatic test_glitchy();
    int k;
    logic saw;
    do_reset();
    pll_locked = 1'b1;
    wait_rst(1'b0, 100, k);
    total++; if (k !== 19) begin bad++; $display("FAIL glitch_rst_fall: got %0d want 19", k); end
    saw = 1'b0;
    k = 0;
    while (idelayctrl_rst !== 1'b1 && k < 5000) begin
      idelay_ctrl_rdy = ((k % 6) != 5);
      tick(1);
      k++;
      if (phy_init_en === 1'b1) saw = 1'b1;
    end
    total++; if (k !== 4096) begin bad++; $display("FAIL glitch_tmo: got %0d want 4096", k); end
    total++; if (saw !== 1'b0) begin bad++; $display("FAIL glitch_phy_seen: got %b want 0", saw); end
    total++; if (retry_cnt !== 3'd1) begin bad++; $display("FAIL glitch_retry: got %0d want 1", retry_cnt); end
  endtask

  task automatic test_hold_reset();
    int k;
    do_reset();
    pll_locked = 1'b1;
    wait_rst(1'b0, 100, k);
    idelay_ctrl_rdy = 1'b1;
    wait_phy(1'b1, 100, k);
    idelay_ctrl_rdy = 1'b0;
    wait_phy(1'b0, 100, k);
    total++; if (retry_cnt !== 3'd1) begin bad++; $display("FAIL hold_pre_retry: got %0d want 1", retry_cnt); end
    tick(5);
    #2 rst200 = 1'b1;
    #1;
    total++; if (retry_cnt !== 3'd0) begin bad++; $display("FAIL hold_async_retry: got %0d want 0", retry_cnt); end
    total++; if (idelayctrl_rst !== 1'b1) begin bad++; $display("FAIL hold_async_rst: got %b want 1", idelayctrl_rst); end
    total++; if (phy_init_en !== 1'b0) begin bad++; $display("FAIL hold_async_phy: got %b want 0", phy_init_en); end
    tick(2);
    rst200 = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_nominal();
    test_rdy_loss();
    test_lock_loss();
    test_timeout_retry();
    test_exhaustion();
    test_glitchy();
    test_hold_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
